// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, configurable data and stop length.
// Reports each frame with a one-clock done pulse plus a stop-bit framing flag.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_Tick = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            rx_busy
);

  localparam int SW = $clog2(SB_Tick);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_Tick - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            rx_meta;
  logic            rx_s;

  // Two-flop synchronizer; resets to the idle line level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            s     <= '0;
            state <= START;
          end
        end
        // Resample mid start bit; a line already high again is treated as a glitch.
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              s     <= '0;
              n     <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == N_LAST) state <= STOP;
              else             n     <= n + NW'(1);
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              state        <= IDLE;
              dout         <= b;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a queue-based reference of sent words.
// A second instance with a two-stop-bit setting covers slow ticks and stop timing.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       s_tick;
  logic       rx;
  logic       rx2;
  logic [7:0] dout;
  logic [7:0] dout2;
  logic       rx_done_tick;
  logic       rx_done_tick2;
  logic       frame_err;
  logic       frame_err2;
  logic       rx_busy;
  logic       rx_busy2;

  int tests_run = 0;
  int fail_cnt  = 0;
  int tick_period = 1;
  int tick_cnt = 0;
  int tick_total = 0;
  int fall_tick = 0;
  int done_tick2 = 0;

  logic [8:0] exp_q[$];
  logic [8:0] act_q[$];
  logic [8:0] exp2_q[$];
  logic [8:0] act2_q[$];

  uart_rx #(.DBIT(8), .SB_Tick(16)) dut (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx),
    .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  uart_rx #(.DBIT(8), .SB_Tick(32)) dut2 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx2),
    .dout(dout2), .rx_done_tick(rx_done_tick2), .frame_err(frame_err2), .rx_busy(rx_busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt = (tick_cnt + 1 >= tick_period) ? 0 : tick_cnt + 1;
      s_tick   = (tick_cnt == 0);
    end
  end

  always @(posedge clk) if (s_tick === 1'b1) tick_total++;

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) act_q.push_back({frame_err, dout});
    if (rx_done_tick2 === 1'b1) begin
      act2_q.push_back({frame_err2, dout2});
      done_tick2 = tick_total;
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitTicks(input int k);
    repeat (k) begin
      do @(posedge clk); while (s_tick !== 1'b1);
    end
    @(negedge clk);
  endtask

  // Sends one frame tick-aligned; a low stop bit is released early so the
  // line reads as a rejected glitch afterwards rather than a new frame.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_hi,
                               input int stop_ticks, input bit second);
    if (second) begin
      rx2 = 1'b0;
      fall_tick = tick_total;
    end else begin
      rx = 1'b0;
    end
    waitTicks(16);
    for (int i = 0; i < 8; i++) begin
      if (second) rx2 = data[i];
      else        rx  = data[i];
      waitTicks(16);
    end
    if (stop_hi) begin
      if (second) rx2 = 1'b1;
      else        rx  = 1'b1;
      waitTicks(stop_ticks);
    end else begin
      if (second) rx2 = 1'b0;
      else        rx  = 1'b0;
      waitTicks(stop_ticks / 2 + 2);
      if (second) rx2 = 1'b1;
      else        rx  = 1'b1;
      waitTicks(stop_ticks / 2 - 2 + 16);
    end
    if (second) exp2_q.push_back({~stop_hi, data});
    else        exp_q.push_back({~stop_hi, data});
  endtask

  task automatic waitDone(input int target);
    for (int i = 0; i < 400 && act_q.size() < target; i++) @(negedge clk);
  endtask

  task automatic checkFrames(input string tag);
    logic [8:0] a;
    logic [8:0] e;
    checkOutput({tag, "_count"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      checkOutput({tag, "_dout"}, a[7:0], e[7:0]);
      checkOutput({tag, "_ferr"}, a[8], e[8]);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] rdata;
    logic       rstop;
    rst = 1'b1;
    rx  = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_dout", dout, 8'h00);
    checkOutput("reset_done", rx_done_tick, 1'b0);
    checkOutput("reset_ferr", frame_err, 1'b0);
    checkOutput("reset_busy", rx_busy, 1'b0);
    checkOutput("reset_busy2", rx_busy2, 1'b0);
    rst = 1'b0;
    waitTicks(20);

    applyStimulus(8'h55, 1'b1, 16, 1'b0);
    waitDone(1);
    checkFrames("f55");

    rx = 1'b0;
    waitTicks(4);
    checkOutput("glitch_busy", rx_busy, 1'b1);
    rx = 1'b1;
    waitTicks(20);
    checkOutput("glitch_idle", rx_busy, 1'b0);
    checkOutput("glitch_none", act_q.size(), 0);
    checkOutput("glitch_dout", dout, 8'h55);

    applyStimulus(8'hA3, 1'b0, 16, 1'b0);
    waitDone(1);
    checkFrames("fA3");

    applyStimulus(8'h01, 1'b1, 16, 1'b0);
    applyStimulus(8'hFF, 1'b1, 16, 1'b0);
    waitDone(2);
    checkFrames("b2b");

    rx = 1'b0;
    waitTicks(16);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      waitTicks(16);
    end
    rx = 1'b1;
    waitTicks(8);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_mid_dout", dout, 8'h00);
    checkOutput("rst_mid_ferr", frame_err, 1'b0);
    checkOutput("rst_mid_done", rx_done_tick, 1'b0);
    checkOutput("rst_mid_busy", rx_busy, 1'b0);
    rst = 1'b0;
    waitTicks(20);
    checkOutput("rst_mid_none", act_q.size(), 0);
    applyStimulus(8'h3C, 1'b1, 16, 1'b0);
    waitDone(1);
    checkFrames("f3C");

    for (int k = 0; k < 6; k++) begin
      rdata = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      applyStimulus(rdata, rstop, 16, 1'b0);
    end
    waitDone(6);
    checkFrames("rand");

    tick_period = 5;
    waitTicks(20);
    applyStimulus(8'hC6, 1'b1, 32, 1'b1);
    repeat (50) @(negedge clk);
    checkOutput("sb32_count", act2_q.size(), exp2_q.size());
    if (act2_q.size() > 0 && exp2_q.size() > 0) begin
      checkOutput("sb32_dout", act2_q[0][7:0], exp2_q[0][7:0]);
      checkOutput("sb32_ferr", act2_q[0][8], exp2_q[0][8]);
    end
    checkOutput("sb32_timing", done_tick2 - fall_tick, 8 + 16 * 8 + 32);
    checkOutput("sb32_other_quiet", act_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
